pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have input CLK, 1 bit: clock; all state updates on posedge.
REQ-002 SHALL have input nRESET, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have inputs id_rs1 and id_rs2, 5 bits each: source register addresses of the instruction in ID.
REQ-004 SHALL have input id_uses_rs2, 1 bit: the ID instruction reads rs2 (R/S/B types).
REQ-005 SHALL have inputs ex_memread, 1 bit, and ex_rd, 5 bits: load flag and destination register of the instruction in EX.
REQ-006 SHALL have input ex_branch_taken, 1 bit: branch or jump taken, resolved in EX.
REQ-007 SHALL have inputs mem_req and mem_ready, 1 bit each: data-memory access is pending in MEM / access completes this cycle.
REQ-008 SHALL have outputs pc_write and ifid_write, 1 bit each: enables for the PC and IF_ID registers.
REQ-009 SHALL have output ifid_flush, 1 bit: loads a NOP (32'h00000013) into IF_ID.
REQ-010 SHALL have output idex_bubble, 1 bit: zeroes RegWrite/MemRead/MemWrite/MemToReg entering ID_EX.
REQ-011 SHALL have outputs idex_hold and exmem_hold, 1 bit each: the ID_EX and EX_MEM registers retain their contents.
REQ-012 SHALL have outputs state, 2 bits, and stall_cnt, 16 bits: current FSM state and accumulated stall cycles.

Function
REQ-013 SHALL implement an FSM with states RUN=0, FLUSH=1 and MEM_WAIT=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-014 SHALL evaluate conditions each cycle in priority order: memwait > branch > loaduse.
- memwait = mem_req & ~mem_ready.
- loaduse = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
REQ-015 SHALL decode all control outputs combinationally from the registered state and the current inputs, with no added latency.
REQ-016 SHALL, on memwait in any state, drive pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1, with no flush and no bubble, and next state MEM_WAIT.
REQ-017 SHALL, on branch without memwait, drive ifid_flush=1 and idex_bubble=1 with pc_write=1, and next state FLUSH.
REQ-018 SHALL, in FLUSH without memwait, drive ifid_flush=1 for one more cycle (synchronous IMEM latency), then return to RUN.
REQ-019 SHALL, in FLUSH with a new branch, behave per REQ-017 and remain in FLUSH.
REQ-020 SHALL, on loaduse in RUN without branch or memwait, drive pc_write=0, ifid_write=0, idex_bubble=1, and remain in RUN (one-cycle bubble).
REQ-021 SHALL, in FLUSH, ignore loaduse because the ID instruction is squashed.
REQ-022 SHALL, in MEM_WAIT once mem_ready=1, apply the RUN rules in that same cycle, with the next state chosen by those rules.
REQ-023 SHALL hold ex_branch_taken and loaduse while in MEM_WAIT (the pipeline is frozen) and act on them at exit per REQ-022.
REQ-024 SHALL, when no condition is active, drive pc_write=1, ifid_write=1, and all other controls 0.
REQ-025 SHALL increment stall_cnt by 1 each cycle pc_write=0, saturating at 16'hFFFF.

Reset
REQ-026 SHALL, while nRESET=0, asynchronously force state=RUN and stall_cnt=0.
- Outputs then read pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, idex_hold=0, exmem_hold=0, provided memwait, branch and loaduse are all 0.
REQ-027 SHALL abandon any FLUSH or MEM_WAIT in progress when reset asserts mid-operation, with no residual flush or hold after release.

Structure
REQ-028 SHALL place the state encodings (RUN/FLUSH/MEM_WAIT), the NOP constant 32'h00000013 and the counter width 16 in the shared pipeline package.
REQ-029 SHALL be implemented as a single module with no sub-modules; the hazard comparator is inline logic.

Verification
REQ-030 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> exactly one cycle with pc_write=0, idex_bubble=1, and stall_cnt increments by 1.
REQ-031 SHALL cover the x0 exemption: ex_memread=1, ex_rd=0, id_rs1=0 -> no stall; and id_uses_rs2=0 with ex_rd=id_rs2=7 -> no stall.
REQ-032 SHALL cover a taken branch: a one-cycle ex_branch_taken pulse -> ifid_flush=1 for 2 cycles, idex_bubble=1 for 1 cycle, state RUN->FLUSH->RUN.
REQ-033 SHALL cover a memory wait: mem_req=1 with mem_ready=0 for 3 cycles -> 3 cycles of holds, state=2, stall_cnt+=3; state returns to RUN when mem_ready=1.
REQ-034 SHALL cover simultaneous events: memwait and branch together for 2 cycles, then mem_ready=1 -> freeze for 2 cycles, then flush, then FLUSH state; no loaduse bubble is issued.
REQ-035 SHALL cover saturation and reset: preload stall_cnt to 16'hFFFE, stall 3 cycles -> 16'hFFFF; then nRESET=0 mid-MEM_WAIT -> state=0 and stall_cnt=0 immediately.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the NOP used to squash IF_ID, and stall-counter sizing.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ILLEGAL  = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int STALL_CNT_W = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_hold;
        logic exmem_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: memory-wait freeze,
// taken-branch flush and load-use bubble, plus a saturating stall counter.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; load-use hazards insert a single bubble
// FLUSH    | second squash cycle after a taken branch (IMEM is synchronous)
// MEM_WAIT | data memory busy, whole pipeline frozen
// (3)      | illegal, recovers to RUN on the next edge
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic                   CLK,
    input  logic                   nRESET,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs2,
    input  logic                   ex_memread,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   idex_hold,
    output logic                   exmem_hold,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_e                   state_q, state_d;
    logic                     branch_pend_q, branch_pend_d;
    logic                     loaduse_pend_q, loaduse_pend_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic  memwait;
    logic  loaduse_now;
    logic  branch;
    logic  loaduse;
    logic  in_wait;
    ctrl_t ctrl;

    assign memwait     = mem_req & ~mem_ready;
    assign loaduse_now = ex_memread & (ex_rd != 5'd0) &
                         ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // Hazards seen while frozen are remembered so they still act at exit,
    // even if the upstream signal is not re-presented on the release cycle.
    assign in_wait = (state_q == ST_MEM_WAIT);
    assign branch  = ex_branch_taken | (in_wait & branch_pend_q);
    assign loaduse = loaduse_now     | (in_wait & loaduse_pend_q);

    assign branch_pend_d  = memwait & (branch_pend_q  | ex_branch_taken);
    assign loaduse_pend_d = memwait & (loaduse_pend_q | loaduse_now);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q        <= ST_RUN;
            branch_pend_q  <= 1'b0;
            loaduse_pend_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            branch_pend_q  <= branch_pend_d;
            loaduse_pend_q <= loaduse_pend_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_FLUSH, ST_MEM_WAIT: begin
                if (memwait)     state_d = ST_MEM_WAIT;
                else if (branch) state_d = ST_FLUSH;
                else             state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (memwait) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_hold  = 1'b1;
            ctrl.exmem_hold = 1'b1;
        end else if (branch) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // The ID instruction is already squashed, so load-use is moot here.
            ctrl.ifid_flush = 1'b1;
        end else if (loaduse) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.idex_bubble = 1'b1;
        end
    end

    assign stall_cnt_d = (!ctrl.pc_write && (stall_cnt_q != STALL_CNT_MAX))
                         ? stall_cnt_q + 1'b1 : stall_cnt_q;

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign idex_hold   = ctrl.idex_hold;
    assign exmem_hold  = ctrl.exmem_hold;
    assign state       = state_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push their expected
// outputs; a monitor pops and compares on the falling edge of each cycle.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    pipeline_ctrl dut (
        .CLK(CLK), .nRESET(nRESET),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .state(state), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}
    localparam logic [5:0] O_RUN  = 6'b110000;
    localparam logic [5:0] O_LU   = 6'b000100;
    localparam logic [5:0] O_BR   = 6'b111100;
    localparam logic [5:0] O_FL   = 6'b111000;
    localparam logic [5:0] O_HOLD = 6'b000011;
    localparam logic [1:0] S_RUN = 2'd0, S_FL = 2'd1, S_MW = 2'd2;

    typedef struct {
        string       lbl;
        logic [5:0]  ctl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_stall = '0;

    task automatic step(input string lbl, input logic rst_n,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic exr, input logic [4:0] rd, input logic br,
                        input logic mreq, input logic mrdy,
                        input logic [5:0] eo, input logic [1:0] est);
        exp_t e;
        @(posedge CLK);
        #1;
        nRESET = rst_n;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_memread = exr; ex_rd = rd; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy;
        e.lbl = lbl; e.ctl = eo; e.st = est;
        e.cnt = rst_n ? exp_stall : 16'h0000;
        sb.push_back(e);
        if (!rst_n) exp_stall = 16'h0000;
        else if (!eo[5] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic idle(input string lbl, input logic [5:0] eo, input logic [1:0] est);
        step(lbl, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, eo, est);
    endtask

    initial begin : monitor
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold};
                checks++;
                if (act !== e.ctl || state !== e.st || stall_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got ctl=%b state=%0d cnt=%h, expected ctl=%b state=%0d cnt=%h",
                             e.lbl, act, state, stall_cnt, e.ctl, e.st, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        step("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN);
        idle("idle_after_reset", O_RUN, S_RUN);

        // load-use on rs1, then released
        step("loaduse_rs1", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
        idle("loaduse_one_cycle", O_RUN, S_RUN);
        step("loaduse_rs2", 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
        step("x0_exempt", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN);
        step("rs2_unused", 1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN);
        step("no_memread", 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN);

        // taken branch pulse: flush 2 cycles, bubble 1
        step("branch", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
        idle("flush_2nd", O_FL, S_FL);
        idle("flush_done", O_RUN, S_RUN);

        // back-to-back branch stays in FLUSH
        step("br_a", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
        step("br_in_flush", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_FL);
        idle("br_b_flush", O_FL, S_FL);
        idle("br_b_done", O_RUN, S_RUN);

        // load-use ignored in FLUSH
        step("br_c", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
        step("lu_in_flush", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_FL, S_FL);
        idle("lu_flush_done", O_RUN, S_RUN);

        // memory wait 3 cycles
        step("mw_1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_RUN);
        step("mw_2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);
        step("mw_3", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);
        step("mw_ready", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RUN, S_MW);
        idle("mw_done", O_RUN, S_RUN);

        // load-use held through a wait, acted on at exit
        step("mw_lu", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, O_HOLD, S_RUN);
        step("mw_lu_exit", 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, O_LU, S_MW);
        idle("mw_lu_done", O_RUN, S_RUN);

        // memwait and branch together
        step("sim_1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_HOLD, S_RUN);
        step("sim_2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, O_HOLD, S_MW);
        step("sim_exit", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, O_BR, S_MW);
        idle("sim_flush", O_FL, S_FL);
        idle("sim_done", O_RUN, S_RUN);

        // memwait arriving during FLUSH
        step("br_d", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
        step("mw_in_flush", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_FL);
        step("mw_fl_exit", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RUN, S_MW);
        idle("mw_fl_done", O_RUN, S_RUN);

        // run the counter up to FFFE, then 3 more stalls to hit saturation
        step("sat_fill_first", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_RUN);
        while (exp_stall != 16'hFFFE)
            step("sat_fill", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);
        step("sat_fffe", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);
        step("sat_ffff", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);
        step("sat_hold", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_HOLD, S_MW);

        // reset mid-MEM_WAIT, then confirm nothing residual
        step("reset_mid_wait", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN, S_RUN);
        idle("post_reset", O_RUN, S_RUN);
        idle("post_reset_2", O_RUN, S_RUN);
        step("post_reset_lu", 1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
        idle("post_reset_cnt", O_RUN, S_RUN);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge CLK);
            guard++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
